// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package hazard_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int DEFAULT_MULDIV_LATENCY = 32;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// ID/EX hazard inputs and pipeline enable outputs between the datapath and the stall controller.
interface hazard_stall_controller_if #(
   parameter int CNT_W       = 8,
   parameter int STALL_CNT_W = 32
);
   logic [4:0]             id_rs;
   logic                   id_rs_used;
   logic [4:0]             id_rt;
   logic                   id_rt_used;
   logic                   id_is_muldiv;
   logic                   id_uses_hilo;
   logic                   id_ex_mem_read;
   logic [4:0]             id_ex_rd;
   logic                   ex_branch_taken;
   logic                   stall_cnt_clr;
   logic                   pc_write;
   logic                   if_id_write;
   logic                   id_ex_bubble;
   logic                   if_id_flush;
   logic                   md_busy;
   logic [CNT_W-1:0]       md_remaining;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rs_used, id_rt, id_rt_used, id_is_muldiv, id_uses_hilo,
             id_ex_mem_read, id_ex_rd, ex_branch_taken, stall_cnt_clr,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
             md_busy, md_remaining, stall_cycles
   );

   modport slave (
      input  id_rs, id_rs_used, id_rt, id_rt_used, id_is_muldiv, id_uses_hilo,
             id_ex_mem_read, id_ex_rd, ex_branch_taken, stall_cnt_clr,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush,
             md_busy, md_remaining, stall_cycles
   );
endinterface

// File: rtl/hazard_stall_controller_muldiv_busy_timer.sv
// Countdown from mult/div issue until HI/LO are valid; tracks RUN/MD_BUSY.
module muldiv_busy_timer
   import hazard_pkg::*;
#(
   parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue,
   output logic             md_busy,
   output logic [CNT_W-1:0] md_remaining,
   output logic             md_last
);

   localparam logic [CNT_W-1:0] LATENCY = CNT_W'(MULDIV_LATENCY);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   md_state_e        state;
   logic [CNT_W-1:0] remaining;

   // A fresh issue in the final busy cycle reloads instead of passing through RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         remaining <= '0;
      end else begin
         case (state)
            RUN: begin
               if (issue) begin
                  state     <= MD_BUSY;
                  remaining <= LATENCY;
               end
            end
            MD_BUSY: begin
               if (remaining == ONE) begin
                  if (issue) begin
                     remaining <= LATENCY;
                  end else begin
                     state     <= RUN;
                     remaining <= '0;
                  end
               end else begin
                  remaining <= remaining - ONE;
               end
            end
            default: begin
               state     <= RUN;
               remaining <= '0;
            end
         endcase
      end
   end

   assign md_busy      = (state == MD_BUSY);
   assign md_remaining = remaining;
   assign md_last      = (state == MD_BUSY) && (remaining == ONE);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / mult-div stall and taken-branch flush control for the 5-stage pipeline.
module hazard_stall_controller
   import hazard_pkg::*;
#(
   parameter int MULDIV_LATENCY = DEFAULT_MULDIV_LATENCY,
   parameter int CNT_W          = 8,
   parameter int STALL_CNT_W    = 32
) (
   input logic                      clk,
   input logic                      rst_n,
   hazard_stall_controller_if.slave bus
);

   logic                   load_hz;
   logic                   md_hz;
   logic                   issue;
   logic                   md_busy;
   logic [CNT_W-1:0]       md_remaining;
   logic                   md_last;
   logic                   pc_write;
   logic                   if_id_write;
   logic                   id_ex_bubble;
   logic                   if_id_flush;
   logic [STALL_CNT_W-1:0] stall_cycles;

   assign load_hz = bus.id_ex_mem_read && (bus.id_ex_rd != REG_ZERO) &&
                    ((bus.id_rs_used && (bus.id_rs == bus.id_ex_rd)) ||
                     (bus.id_rt_used && (bus.id_rt == bus.id_ex_rd)));

   // Releasing in the last busy cycle lands the HI/LO consumer in EX as the result appears.
   assign md_hz = md_busy && (bus.id_uses_hilo || bus.id_is_muldiv) && !md_last;

   assign issue = rst_n && bus.id_is_muldiv && !bus.ex_branch_taken && !load_hz && !md_hz;

   // A taken branch makes the ID instruction wrong-path, so it outranks any stall.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (rst_n) begin
         if (bus.ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (load_hz || md_hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   muldiv_busy_timer #(
      .MULDIV_LATENCY (MULDIV_LATENCY),
      .CNT_W          (CNT_W)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .issue        (issue),
      .md_busy      (md_busy),
      .md_remaining (md_remaining),
      .md_last      (md_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (bus.stall_cnt_clr) begin
         stall_cycles <= '0;
      end else if (!pc_write) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.if_id_write  = if_id_write;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.md_busy      = md_busy;
   assign bus.md_remaining = md_remaining;
   assign bus.stall_cycles = stall_cycles;

endmodule
